dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port.
- Accepts one word read or write request at a time over a valid/ready handshake.
- Services the request from internal word-addressed storage after a programmable wait-state count.
- Returns a response (read data or write acknowledge, plus error flag) over a second valid/ready handshake.
- Replaces the zero-latency data memory so the pipeline can be exercised against realistic stall and backpressure behaviour.

Parameters:
- DWIDTH, 32, data and address width in bits.
- DEPTH, 256, number of words of storage; must be a power of two.
- LATENCY, 2, wait cycles from request acceptance to rsp_valid; minimum 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  DWIDTH  byte address.
- req_wdata  input  DWIDTH  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  DWIDTH  read data; 0 for writes and errors.
- rsp_err  output  1  misaligned or out-of-range access.
- busy  output  1  high whenever not in IDLE.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset (rst low, asynchronous):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, wait counter = 0.
  - Storage contents are not cleared.
- IDLE:
  - req_ready = 1.
  - On req_valid: capture we, addr, wdata; load counter with LATENCY-1; go to WAIT.
- WAIT:
  - req_ready = 0; counter decrements each cycle.
  - When counter is 0, perform the access and go to RESP on the next edge.
  - Net result: rsp_valid rises exactly LATENCY cycles after the accept edge.
- Access rules:
  - Index = addr[log2(DEPTH)+1:2].
  - Error if addr[1:0] != 0, or if addr >= 4*DEPTH.
  - On error: no storage change, rsp_err = 1, rsp_rdata = 0.
  - Valid write: storage updated on the access edge; rsp_rdata = 0.
  - Valid read: rsp_rdata = stored word, sampled on the access edge.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err held stable until the handshake completes.
  - On rsp_ready: next state IDLE, rsp_valid deasserts, rsp_rdata and rsp_err return to 0.
  - req_ready stays 0 in RESP. A new request is accepted no earlier than the cycle after the response handshake; one outstanding transaction maximum.
- Backpressure: rsp_ready may be held low indefinitely; state remains RESP with outputs stable.
- Read-after-write to the same address in back-to-back transactions returns the newly written data.
- req_valid deasserting while in WAIT or RESP has no effect; the captured request completes.
- Reset mid-transaction (WAIT or RESP): the transaction is dropped with no response.
  - A write dropped in WAIT has not modified storage.
  - A write dropped in RESP has already committed.
- Inputs other than req_valid are don't-care in IDLE when req_valid = 0.
- Throughput: one transaction per LATENCY+2 cycles with rsp_ready tied high.

Test Plan:
- Reset then write: write 0xDEADBEEF to 0x10, rsp_ready high -> rsp_valid 2 cycles after accept, rsp_err = 0, rsp_rdata = 0, then read 0x10 returns 0xDEADBEEF.
- Misaligned access: read 0x13 -> rsp_err = 1, rsp_rdata = 0; subsequent read 0x10 still returns 0xDEADBEEF.
- Out of range (DEPTH=256): write 0x400 = 0x1234 -> rsp_err = 1; read 0x0 is unchanged (still its prior value).
- Backpressure: read 0x10 with rsp_ready low for 5 cycles -> rsp_valid stays high, rsp_rdata stable at 0xDEADBEEF, req_ready low throughout; raise rsp_ready -> IDLE next cycle, req_ready = 1.
- LATENCY=1 build: back-to-back write 0x20 = 0xA5A5A5A5 then read 0x20 -> returns 0xA5A5A5A5; accepts are spaced 3 cycles apart.
- Reset mid-WAIT: issue write 0x30 = 0x55, assert rst low during WAIT -> outputs return to reset values immediately, no rsp_valid; after release, read 0x30 returns its pre-write value.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind valid/ready request and response
// handshakes, answering each access after LATENCY wait cycles.
module dmem_responder #(
    parameter int DWIDTH  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [DWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic              bad;
    logic              access;

    assign bad       = addr_q[1:0] != 2'b00 || addr_q >= DWIDTH'(4 * DEPTH);
    assign access    = state_q == WAIT && cnt_q == '0;
    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign busy      = state_q != IDLE;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = WAIT;
                cnt_d   = CW'(LATENCY - 1);
                we_d    = req_we;
                addr_d  = req_addr;
                wdata_d = req_wdata;
            end
            WAIT: if (cnt_q == '0) begin
                state_d = RESP;
                err_d   = bad;
                rdata_d = (bad || we_q) ? '0 : mem[addr_q[AW+1:2]];
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            RESP: if (rsp_ready) begin
                state_d = IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage survives reset; only the access edge of a valid write touches it.
    always_ff @(posedge clk) begin
        if (access && we_q && !bad)
            mem[addr_q[AW+1:2]] <= wdata_q;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scenarios for dmem_responder against an array-based memory model.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        req_valid_1 = 1'b0, req_ready_1, req_we_1 = 1'b0;
    logic [31:0] req_addr_1 = '0, req_wdata_1 = '0;
    logic        rsp_valid_1, rsp_ready_1 = 1'b0, rsp_err_1, busy_1;
    logic [31:0] rsp_rdata_1;
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    logic [31:0] mem_m [256];

    dmem_responder dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid_1), .req_ready(req_ready_1), .req_we(req_we_1),
        .req_addr(req_addr_1), .req_wdata(req_wdata_1), .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1),
        .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1), .busy(busy_1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model(input logic we, input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] rd, output logic er);
        er = a[1:0] != 2'b00 || a >= 32'h400;
        rd = (er || we) ? 32'h0 : mem_m[a / 4];
        if (!er && we) mem_m[a / 4] = d;
    endfunction

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d);
        int g = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        while (!req_ready && g < 50) begin @(negedge clk); g++; end
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic await_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        if (!rsp_valid) lat = -1;
    endtask

    task automatic finish_rsp(output logic [31:0] rd, output logic er);
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
        issue(we, a, d);
        await_rsp(lat);
        repeat (hold) @(negedge clk);
        finish_rsp(rd, er);
    endtask

    task automatic test_reset;
        #1;
        n_total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", rsp_rdata); else n_pass++;
        n_total++; if (rsp_err !== 1'b0) $display("FAIL rst_err: got %b want 0", rsp_err); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fill;
        logic [31:0] rd, d;
        logic er;
        int lat, nbad = 0;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            txn(1'b1, 32'(i * 4), d, 0, rd, er, lat);
            mem_m[i] = d;
            if (er !== 1'b0 || lat !== 2) nbad++;
        end
        n_total++; if (nbad !== 0) $display("FAIL fill: got %0d bad writes want 0", nbad); else n_pass++;
    endtask

    task automatic test_write_read;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        model(1'b1, 32'h10, 32'hDEADBEEF, erd, eer);
        txn(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
        n_total++; if (lat !== 2) $display("FAIL wr_latency: got %0d want 2", lat); else n_pass++;
        n_total++; if (er !== 1'b0) $display("FAIL wr_err: got %b want 0", er); else n_pass++;
        n_total++; if (rd !== 32'h0) $display("FAIL wr_rdata: got %h want 0", rd); else n_pass++;
        txn(1'b0, 32'h10, 32'h0, 0, rd, er, lat);
        n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_after_wr: got %h want deadbeef", rd); else n_pass++;
        n_total++; if (er !== 1'b0) $display("FAIL rd_err: got %b want 0", er); else n_pass++;
    endtask

    task automatic test_misaligned;
        logic [31:0] rd;
        logic er;
        int lat;
        txn(1'b0, 32'h13, 32'h0, 0, rd, er, lat);
        n_total++; if (er !== 1'b1) $display("FAIL misal_err: got %b want 1", er); else n_pass++;
        n_total++; if (rd !== 32'h0) $display("FAIL misal_rdata: got %h want 0", rd); else n_pass++;
        txn(1'b0, 32'h10, 32'h0, 0, rd, er, lat);
        n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL misal_reread: got %h want deadbeef", rd); else n_pass++;
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd;
        logic er;
        int lat;
        txn(1'b1, 32'h400, 32'h1234, 0, rd, er, lat);
        n_total++; if (er !== 1'b1) $display("FAIL oor_err: got %b want 1", er); else n_pass++;
        n_total++; if (rd !== 32'h0) $display("FAIL oor_rdata: got %h want 0", rd); else n_pass++;
        txn(1'b0, 32'h0, 32'h0, 0, rd, er, lat);
        n_total++; if (rd !== mem_m[0]) $display("FAIL oor_word0: got %h want %h", rd, mem_m[0]); else n_pass++;
    endtask

    task automatic test_backpressure;
        int lat;
        issue(1'b0, 32'h10, 32'h0);
        await_rsp(lat);
        n_total++; if (lat !== 2) $display("FAIL bp_latency: got %0d want 2", lat); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, rsp_valid); else n_pass++;
            n_total++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL bp_rdata[%0d]: got %h want deadbeef", i, rsp_rdata); else n_pass++;
            n_total++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready); else n_pass++;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL bp_done_valid: got %b want 0", rsp_valid); else n_pass++;
        n_total++; if (req_ready !== 1'b1) $display("FAIL bp_done_ready: got %b want 1", req_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL bp_done_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (rsp_rdata !== 32'h0) $display("FAIL bp_done_rdata: got %h want 0", rsp_rdata); else n_pass++;
    endtask

    task automatic test_latency1;
        int g, t0, t1;
        @(negedge clk);
        rsp_ready_1 = 1'b1;
        req_valid_1 = 1'b1; req_we_1 = 1'b1; req_addr_1 = 32'h20; req_wdata_1 = 32'hA5A5A5A5;
        g = 0;
        while (!req_ready_1 && g < 50) begin @(negedge clk); g++; end
        t0 = cyc;
        @(negedge clk);
        req_we_1 = 1'b0; req_wdata_1 = $urandom;
        g = 0;
        while (!req_ready_1 && g < 50) begin @(negedge clk); g++; end
        t1 = cyc;
        @(negedge clk);
        req_valid_1 = 1'b0;
        n_total++; if (t1 - t0 !== 3) $display("FAIL lat1_spacing: got %0d want 3", t1 - t0); else n_pass++;
        g = 0;
        while (!rsp_valid_1 && g < 50) begin @(negedge clk); g++; end
        n_total++; if (rsp_valid_1 !== 1'b1) $display("FAIL lat1_rsp_timeout: got %b want 1", rsp_valid_1); else n_pass++;
        n_total++; if (rsp_rdata_1 !== 32'hA5A5A5A5) $display("FAIL lat1_raw: got %h want a5a5a5a5", rsp_rdata_1); else n_pass++;
        n_total++; if (rsp_err_1 !== 1'b0) $display("FAIL lat1_err: got %b want 0", rsp_err_1); else n_pass++;
        @(negedge clk);
        rsp_ready_1 = 1'b0;
    endtask

    task automatic test_reset_wait;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        model(1'b1, 32'h30, 32'hCAFEF00D, erd, eer);
        txn(1'b1, 32'h30, 32'hCAFEF00D, 0, rd, er, lat);
        issue(1'b1, 32'h30, 32'h55);
        n_total++; if (busy !== 1'b1) $display("FAIL rw_in_wait: got busy %b want 1", busy); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL rw_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (req_ready !== 1'b1) $display("FAIL rw_req_ready: got %b want 1", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL rw_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL rw_no_rsp: got %b want 0", rsp_valid); else n_pass++;
        txn(1'b0, 32'h30, 32'h0, 0, rd, er, lat);
        n_total++; if (rd !== 32'hCAFEF00D) $display("FAIL rw_storage: got %h want cafef00d", rd); else n_pass++;
    endtask

    task automatic test_reset_resp;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        issue(1'b1, 32'h40, 32'h0BADF00D);
        await_rsp(lat);
        n_total++; if (lat !== 2) $display("FAIL rr_latency: got %0d want 2", lat); else n_pass++;
        model(1'b1, 32'h40, 32'h0BADF00D, erd, eer);
        #2 rst = 1'b0;
        #1;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL rr_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        n_total++; if (rsp_rdata !== 32'h0) $display("FAIL rr_rdata: got %h want 0", rsp_rdata); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        txn(1'b0, 32'h40, 32'h0, 0, rd, er, lat);
        n_total++; if (rd !== 32'h0BADF00D) $display("FAIL rr_committed: got %h want 0badf00d", rd); else n_pass++;
    endtask

    task automatic test_random;
        logic [31:0] a, d, rd, erd;
        logic we, er, eer;
        int lat, hold;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom);
            d = $urandom;
            hold = $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0: a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
                1: a = 32'h400 + (32'($urandom_range(0, 4000)) << 2);
                2, 3, 4: a = 32'($urandom_range(0, 7)) << 2;
                default: a = 32'($urandom_range(0, 255)) << 2;
            endcase
            model(we, a, d, erd, eer);
            txn(we, a, d, hold, rd, er, lat);
            n_total++; if (lat !== 2) $display("FAIL rnd_latency[%0d]: got %0d want 2", i, lat); else n_pass++;
            n_total++; if (er !== eer) $display("FAIL rnd_err[%0d] addr %h: got %b want %b", i, a, er, eer); else n_pass++;
            n_total++; if (rd !== erd) $display("FAIL rnd_rdata[%0d] addr %h we %b: got %h want %h", i, a, we, rd, erd); else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_write_read;
        test_misaligned;
        test_out_of_range;
        test_backpressure;
        test_latency1;
        test_reset_wait;
        test_reset_resp;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
